ntt_host_sequencer: RTL

Host-side initiator for the NTTN core's load/start/done protocol.
- Accepts one command at a time (load twiddles, forward NTT, inverse NTT) plus a valid/ready input word stream.
- Generates the single-cycle load_w/load_data/start/start_intt pulses and the gap-free din burst that NTTN needs.
- After done, captures the RING_SIZE-word dout burst and re-emits it as an output stream with a last flag.
- Sits between a host bus/DMA and the NTTN instance.

---
 rtl/ntt_seq_pkg.sv | 43 ++++
 rtl/ntt_seq_burst_cnt.sv | 35 +++
 rtl/ntt_host_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ntt_seq_pkg.sv
// ntt_seq_pkg
// Shared types and sizing helpers for the NTTN host sequencer.
//   op_e      : host command encodings carried on cmd_op
//   state_e   : sequencer FSM states
//   ring_size : number of coefficients in one transform
//   w_count   : number of twiddle words in one W (or WINV) table
//   loadw_len : full LOADW burst length (W, WINV, q, n_inv)
package ntt_seq_pkg;

   typedef enum logic [1:0] {
      OP_LOADW = 2'd0,
      OP_NTT   = 2'd1,
      OP_INTT  = 2'd2,
      OP_RSVD  = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      IDLE,
      PULSE,
      STREAM,
      GAP,
      START,
      WAIT_DONE,
      DRAIN
   } state_e;

   function automatic int ring_size(input int ring_depth);
      return 1 << ring_depth;
   endfunction

   function automatic int w_count(input int ring_depth, input int pe_depth);
      return (((1 << (ring_depth - pe_depth)) - 1) + pe_depth) << pe_depth;
   endfunction

   function automatic int loadw_len(input int ring_depth, input int pe_depth);
      return 2 * w_count(ring_depth, pe_depth) + 2;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ntt_seq_burst_cnt.sv
// ntt_seq_burst_cnt
// Loadable down-counter with a terminal-count (zero) flag. The count
// saturates at zero, so a held dec never wraps.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one when non-zero
//   zero       : count is zero
module ntt_seq_burst_cnt #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/ntt_host_sequencer.sv
// ntt_host_sequencer
// Host-side initiator for the NTTN load/start/done protocol. Takes one
// command at a time, pushes a gap-free din burst behind a load pulse,
// starts the transform, then re-emits the dout burst as a stream.
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_op : command handshake (0 LOADW, 1 NTT, 2 INTT)
//   s_valid/s_ready/s_data     : input word stream (ready only while streaming)
//   m_valid/m_data/m_last      : output word stream, no backpressure
//   busy, err                  : not idle; sticky error (underrun/bad op/timeout)
//   load_w/load_data/start/start_intt/din : drive NTTN
//   done/dout                  : from NTTN
// Optional feature macro: NTT_SEQ_TIMEOUT_EN adds a WAIT_DONE watchdog of
// TIMEOUT_CYC cycles; without it WAIT_DONE waits forever.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for a command, cmd_ready high
// PULSE     | one cycle; load_w or load_data asserted on the next edge
// STREAM    | s_ready high, one word per cycle onto din, underrun -> 0
// GAP       | GAP_CYC quiet cycles before the start pulse
// START     | one cycle; start or start_intt asserted on the next edge
// WAIT_DONE | waiting for done (optional watchdog)
// DRAIN     | OUT_SKEW-1 skip cycles, then RING_SIZE dout words out
module ntt_host_sequencer
   import ntt_seq_pkg::*;
#(
   parameter int DATA_SIZE   = 32,
   parameter int RING_DEPTH  = 12,
   parameter int PE_DEPTH    = 3,
   parameter int GAP_CYC     = 5,
   parameter int OUT_SKEW    = 1,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [DATA_SIZE-1:0] s_data,
   output logic                 m_valid,
   output logic [DATA_SIZE-1:0] m_data,
   output logic                 m_last,
   output logic                 busy,
   output logic                 err,
   output logic                 load_w,
   output logic                 load_data,
   output logic                 start,
   output logic                 start_intt,
   output logic [DATA_SIZE-1:0] din,
   input  logic                 done,
   input  logic [DATA_SIZE-1:0] dout
);

   localparam int RING_SIZE = ring_size(RING_DEPTH);
   localparam int LOADW_LEN = loadw_len(RING_DEPTH, PE_DEPTH);
   localparam int STREAM_W  = $clog2(max2(LOADW_LEN, RING_SIZE) + 1);
   localparam int GAP_W     = $clog2(max2(GAP_CYC, OUT_SKEW) + 1);
   localparam int DRAIN_W   = $clog2(RING_SIZE + 1);

   // Counters are loaded with length-1 and the last cycle is the one
   // where the zero flag is seen.
   localparam logic [STREAM_W-1:0] LOADW_LAST  = STREAM_W'(LOADW_LEN - 1);
   localparam logic [STREAM_W-1:0] RING_LAST_S = STREAM_W'(RING_SIZE - 1);
   localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(GAP_CYC - 1);
   localparam logic [GAP_W-1:0]    SKEW_LAST   = GAP_W'(OUT_SKEW - 1);
   localparam logic [DRAIN_W-1:0]  RING_LAST_D = DRAIN_W'(RING_SIZE - 1);

   state_e state;
   op_e    op_q;

   logic stream_zero;
   logic gap_zero;
   logic drain_zero;
   logic done_hit;

   assign cmd_ready = (state == IDLE);
   assign s_ready   = (state == STREAM);
   assign busy      = (state != IDLE);
   assign done_hit  = (state == WAIT_DONE) && done;

   ntt_seq_burst_cnt #(.WIDTH(STREAM_W)) u_stream_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (state == PULSE),
      .load_val ((op_q == OP_LOADW) ? LOADW_LAST : RING_LAST_S),
      .dec      (state == STREAM),
      .zero     (stream_zero)
   );

   // Shared between the pre-start gap and the post-done output skew; the
   // two uses never overlap.
   ntt_seq_burst_cnt #(.WIDTH(GAP_W)) u_gap_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (((state == STREAM) && stream_zero) || done_hit),
      .load_val ((state == STREAM) ? GAP_LAST : SKEW_LAST),
      .dec      ((state == GAP) || (state == DRAIN)),
      .zero     (gap_zero)
   );

   ntt_seq_burst_cnt #(.WIDTH(DRAIN_W)) u_drain_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (done_hit),
      .load_val (RING_LAST_D),
      .dec      ((state == DRAIN) && gap_zero),
      .zero     (drain_zero)
   );

`ifdef NTT_SEQ_TIMEOUT_EN
   localparam int                TO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   logic to_zero;

   ntt_seq_burst_cnt #(.WIDTH(TO_W)) u_timeout_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (state == START),
      .load_val (TO_LAST),
      .dec      (state == WAIT_DONE),
      .zero     (to_zero)
   );
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         op_q       <= OP_LOADW;
         err        <= 1'b0;
         load_w     <= 1'b0;
         load_data  <= 1'b0;
         start      <= 1'b0;
         start_intt <= 1'b0;
         din        <= '0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_last     <= 1'b0;
      end else begin
         load_w     <= 1'b0;
         load_data  <= 1'b0;
         start      <= 1'b0;
         start_intt <= 1'b0;
         din        <= '0;
         m_valid    <= 1'b0;
         m_last     <= 1'b0;

         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  if (op_e'(cmd_op) == OP_RSVD) begin
                     err <= 1'b1;
                  end else begin
                     op_q  <= op_e'(cmd_op);
                     err   <= 1'b0;
                     state <= PULSE;
                  end
               end
            end
            PULSE: begin
               load_w    <= (op_q == OP_LOADW);
               load_data <= (op_q != OP_LOADW);
               state     <= STREAM;
            end
            STREAM: begin
               // NTTN cannot stall, so an underrun becomes a zero word.
               if (s_valid) begin
                  din <= s_data;
               end else begin
                  err <= 1'b1;
               end
               if (stream_zero) begin
                  state <= (op_q == OP_LOADW) ? IDLE : GAP;
               end
            end
            GAP: begin
               if (gap_zero) begin
                  state <= START;
               end
            end
            START: begin
               start      <= (op_q == OP_NTT);
               start_intt <= (op_q == OP_INTT);
               state      <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (done) begin
                  state <= DRAIN;
`ifdef NTT_SEQ_TIMEOUT_EN
               end else if (to_zero) begin
                  err   <= 1'b1;
                  state <= IDLE;
`endif
               end
            end
            DRAIN: begin
               if (gap_zero) begin
                  m_valid <= 1'b1;
                  m_data  <= dout;
                  m_last  <= drain_zero;
                  if (drain_zero) begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
